// File: rtl/hazard_forward_unit_if.sv
// Bundle of ID/EX hazard signals between the pipeline control and the hazard/forward unit.
// Ports: i_* are driven by the pipeline (master) into the unit (slave); o_* come back.
// HFU_PERF_CNT_EN adds the o_stall_cycles / o_stall_events counter outputs.
interface hazard_forward_unit_if #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MAX_LAT        = 7
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

  logic [NUM_SRC*5-1:0]        i_id_rs;
  logic [NUM_SRC*5-1:0]        i_ex_rs;
  logic [NUM_FWD_STAGES*5-1:0] i_stage_rd;
  logic [NUM_FWD_STAGES-1:0]   i_stage_we;
  logic [NUM_FWD_STAGES-1:0]   i_stage_fwd_ok;
  logic                        i_issue_valid;
  logic [4:0]                  i_issue_rd;
  logic                        i_issue_we;
  logic [LAT_W-1:0]            i_issue_lat;
  logic [NUM_SRC*SEL_W-1:0]    o_fwd_sel;
  logic                        o_stall;
  logic                        o_busy_any;
`ifdef HFU_PERF_CNT_EN
  logic [31:0]                 o_stall_cycles;
  logic [31:0]                 o_stall_events;
`endif

  modport master (
`ifdef HFU_PERF_CNT_EN
    input  o_stall_cycles, o_stall_events,
`endif
    output i_id_rs, i_ex_rs, i_stage_rd, i_stage_we, i_stage_fwd_ok,
    output i_issue_valid, i_issue_rd, i_issue_we, i_issue_lat,
    input  o_fwd_sel, o_stall, o_busy_any
  );

  modport slave (
`ifdef HFU_PERF_CNT_EN
    output o_stall_cycles, o_stall_events,
`endif
    input  i_id_rs, i_ex_rs, i_stage_rd, i_stage_we, i_stage_fwd_ok,
    input  i_issue_valid, i_issue_rd, i_issue_we, i_issue_lat,
    output o_fwd_sel, o_stall, o_busy_any
  );
endinterface

// File: rtl/hazard_forward_unit.sv
// Forward-select generation for EX operands plus a per-register countdown scoreboard that stalls ID.
// Latency: forward selects and stall are combinational; scoreboard updates on the next i_clk edge.
// Backpressure: o_stall holds PC/IF/ID; issues presented while stalled are ignored by the scoreboard.
// Ports: i_clk, i_rst_n (synchronous, active low), hfu (slave side of hazard_forward_unit_if).
// Optional: HFU_PERF_CNT_EN adds 32-bit stall-cycle and stall-event counters.
module hazard_forward_unit #(
  parameter int NUM_SRC        = 2,
  parameter int NUM_FWD_STAGES = 2,
  parameter int MAX_LAT        = 7
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  hazard_forward_unit_if.slave hfu
);
  localparam int LAT_W = $clog2(MAX_LAT + 1);
  localparam int SEL_W = $clog2(NUM_FWD_STAGES + 1);

  // Entry 0 exists only to make cnt[rs] indexing uniform; it is held at zero.
  logic [LAT_W-1:0]         cnt [0:31];
  logic [LAT_W-1:0]         lat_c;
  logic                     iss;
  logic                     stall;
  logic                     busy_any;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;

  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

  assign lat_c = (hfu.i_issue_lat > LAT_W'(MAX_LAT)) ? LAT_W'(MAX_LAT) : hfu.i_issue_lat;

  assign iss = hfu.i_issue_valid & ~stall & hfu.i_issue_we &
               (hfu.i_issue_rd != 5'd0) & (hfu.i_issue_lat != '0);

  // Forwarding: first tap (youngest first) that is writing rs with usable data wins.
  // A younger match whose data is not yet present is skipped rather than blocking.
  always_comb begin
    fwd_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      logic found;
      found = 1'b0;
      for (int t = 0; t < NUM_FWD_STAGES; t++) begin
        if (!found && hfu.i_stage_we[t] && hfu.i_stage_fwd_ok[t] &&
            (hfu.i_stage_rd[t*5 +: 5] != 5'd0) &&
            (hfu.i_stage_rd[t*5 +: 5] == hfu.i_ex_rs[k*5 +: 5])) begin
          fwd_sel[k*SEL_W +: SEL_W] = SEL_W'(t + 1);
          found = 1'b1;
        end
      end
    end
  end

  // Stall: source busy in the scoreboard, or being produced by a multi-cycle op
  // issuing right now. Raw issue_valid is used so stall does not depend on itself.
  always_comb begin
    stall = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      logic [4:0] rs;
      rs = hfu.i_id_rs[k*5 +: 5];
      if (rs != 5'd0) begin
        if (cnt[rs] != '0)
          stall = 1'b1;
        if (hfu.i_issue_valid && hfu.i_issue_we && (hfu.i_issue_lat != '0) &&
            (hfu.i_issue_rd == rs))
          stall = 1'b1;
      end
    end
  end

  always_comb begin
    busy_any = 1'b0;
    for (int r = 1; r < 32; r++)
      if (cnt[r] != '0)
        busy_any = 1'b1;
  end

  // WAW to a busy register keeps whichever result is further away.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int r = 0; r < 32; r++)
        cnt[r] <= '0;
    end else begin
      cnt[0] <= '0;
      for (int r = 1; r < 32; r++) begin
        if (iss && (hfu.i_issue_rd == 5'(r)))
          cnt[r] <= (lat_c > sat_dec(cnt[r])) ? lat_c : sat_dec(cnt[r]);
        else
          cnt[r] <= sat_dec(cnt[r]);
      end
    end
  end

  assign hfu.o_fwd_sel  = fwd_sel;
  assign hfu.o_stall    = stall;
  assign hfu.o_busy_any = busy_any;

`ifdef HFU_PERF_CNT_EN
  logic        stall_d;
  logic [31:0] stall_cycles;
  logic [31:0] stall_events;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      stall_d      <= 1'b0;
      stall_cycles <= '0;
      stall_events <= '0;
    end else begin
      stall_d <= stall;
      if (stall)
        stall_cycles <= stall_cycles + 32'd1;
      if (stall && !stall_d)
        stall_events <= stall_events + 32'd1;
    end
  end

  assign hfu.o_stall_cycles = stall_cycles;
  assign hfu.o_stall_events = stall_events;
`endif
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench for hazard_forward_unit: expected responses queued by the driver, checked by a monitor.
// Defaults: NUM_SRC=2, NUM_FWD_STAGES=2, MAX_LAT=7 -> LAT_W=3, SEL_W=2, o_fwd_sel = {op1, op0}.
// Define HFU_PERF_CNT_EN to also check the stall counters.
module tb_hazard_forward_unit;
  logic i_clk = 1'b0;
  logic i_rst_n;
  always #5 i_clk = ~i_clk;

  hazard_forward_unit_if #(.NUM_SRC(2), .NUM_FWD_STAGES(2), .MAX_LAT(7)) hfu_if ();

  hazard_forward_unit #(.NUM_SRC(2), .NUM_FWD_STAGES(2), .MAX_LAT(7)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .hfu     (hfu_if.slave)
  );

  typedef struct {
    string      name;
    logic [3:0] sel;
    logic       stall;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  logic chk_vld = 1'b0;
  int   total = 0;
  int   bad   = 0;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge i_clk) begin
    if (chk_vld) begin
      exp_t e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL monitor_underflow: no expected entry queued");
      end else begin
        e = exp_q.pop_front();
        if (hfu_if.o_fwd_sel !== e.sel) begin
          bad++;
          $display("FAIL %s fwd_sel: got %b want %b", e.name, hfu_if.o_fwd_sel, e.sel);
        end
        total++;
        if (hfu_if.o_stall !== e.stall) begin
          bad++;
          $display("FAIL %s stall: got %b want %b", e.name, hfu_if.o_stall, e.stall);
        end
        total++;
        if (hfu_if.o_busy_any !== e.busy) begin
          bad++;
          $display("FAIL %s busy_any: got %b want %b", e.name, hfu_if.o_busy_any, e.busy);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    hfu_if.i_id_rs        = '0;
    hfu_if.i_ex_rs        = '0;
    hfu_if.i_stage_rd     = '0;
    hfu_if.i_stage_we     = '0;
    hfu_if.i_stage_fwd_ok = '0;
    hfu_if.i_issue_valid  = 1'b0;
    hfu_if.i_issue_rd     = '0;
    hfu_if.i_issue_we     = 1'b0;
    hfu_if.i_issue_lat    = '0;
  endtask

  task automatic taps(input logic [4:0] rd0, input logic we0, input logic ok0,
                      input logic [4:0] rd1, input logic we1, input logic ok1);
    hfu_if.i_stage_rd     = {rd1, rd0};
    hfu_if.i_stage_we     = {we1, we0};
    hfu_if.i_stage_fwd_ok = {ok1, ok0};
  endtask

  task automatic issue(input logic v, input logic [4:0] rd, input logic we, input logic [2:0] lat);
    hfu_if.i_issue_valid = v;
    hfu_if.i_issue_rd    = rd;
    hfu_if.i_issue_we    = we;
    hfu_if.i_issue_lat   = lat;
  endtask

  // Queue the expectation for the current inputs and advance one cycle.
  task automatic step(input string name, input logic [3:0] sel, input logic stall, input logic busy);
    exp_t e;
    e.name = name; e.sel = sel; e.stall = stall; e.busy = busy;
    exp_q.push_back(e);
    chk_vld = 1'b1;
    @(posedge i_clk);
    #1;
    chk_vld = 1'b0;
  endtask

  initial begin
    i_rst_n = 1'b0;
    idle();
    repeat (2) @(posedge i_clk);
    #1;
    step("reset_idle", 4'b0000, 1'b0, 1'b0);
    i_rst_n = 1'b1;

    // Reset discards a pending entry
    issue(1, 5'd5, 1, 3'd3);
    step("rst_preload_issue", 4'b0000, 1'b0, 1'b0);
    idle(); i_rst_n = 1'b0;
    hfu_if.i_id_rs = {5'd5, 5'd0};
    step("rst_preload_busy", 4'b0000, 1'b1, 1'b1);
    i_rst_n = 1'b1;
    hfu_if.i_id_rs = {5'd0, 5'd5};
    step("rst_cleared", 4'b0000, 1'b0, 1'b0);

    // Forwarding
    idle();
    taps(5'd3, 1, 1, 5'd3, 1, 1); hfu_if.i_ex_rs = {5'd0, 5'd3};
    step("fwd_tap0_youngest", 4'b0001, 1'b0, 1'b0);
    taps(5'd3, 0, 1, 5'd3, 1, 1);
    step("fwd_tap1_we0", 4'b0010, 1'b0, 1'b0);
    taps(5'd0, 1, 1, 5'd0, 1, 1); hfu_if.i_ex_rs = '0;
    step("fwd_x0_never", 4'b0000, 1'b0, 1'b0);
    taps(5'd7, 1, 0, 5'd7, 1, 1); hfu_if.i_ex_rs = {5'd7, 5'd0};
    step("fwd_load_fallthrough", 4'b1000, 1'b0, 1'b0);
    taps(5'd7, 1, 0, 5'd8, 1, 1);
    step("fwd_none_ok", 4'b0000, 1'b0, 1'b0);
    taps(5'd6, 1, 1, 5'd3, 1, 1); hfu_if.i_ex_rs = {5'd6, 5'd3};
    step("fwd_two_operands", 4'b0110, 1'b0, 1'b0);

    // Raw issue-cycle term: stall asserts, and the stalled issue is not recorded
    idle();
    issue(1, 5'd7, 1, 3'd1); hfu_if.i_id_rs = {5'd7, 5'd0};
    step("issue_same_cycle_stall", 4'b0000, 1'b1, 1'b0);
    idle(); hfu_if.i_id_rs = {5'd7, 5'd0};
    step("stalled_issue_ignored", 4'b0000, 1'b0, 1'b0);
    issue(1, 5'd7, 1, 3'd0);
    step("issue_lat0_no_stall", 4'b0000, 1'b0, 1'b0);
    issue(1, 5'd7, 0, 3'd2);
    step("issue_we0_no_stall", 4'b0000, 1'b0, 1'b0);
    idle(); issue(1, 5'd0, 1, 3'd2);
    step("issue_rd0_no_effect", 4'b0000, 1'b0, 1'b0);

    // Load-use, dependent arrives the cycle after the load issues
    idle(); issue(1, 5'd7, 1, 3'd1);
    step("load_issue", 4'b0000, 1'b0, 1'b0);
    idle(); hfu_if.i_id_rs = {5'd7, 5'd0};
    step("load_use_stall", 4'b0000, 1'b1, 1'b1);
    taps(5'd7, 1, 0, 5'd7, 1, 1); hfu_if.i_ex_rs = {5'd0, 5'd7};
    step("load_use_release", 4'b0010, 1'b0, 1'b0);

    // Mul lat=4: cnt 4,3,2,1; issues attempted while stalled must not reload
    idle(); issue(1, 5'd9, 1, 3'd4);
    step("mul_issue", 4'b0000, 1'b0, 1'b0);
    hfu_if.i_id_rs = {5'd0, 5'd9};
    for (int i = 0; i < 4; i++) begin
      issue(1, 5'd9, 1, 3'd7);
      step($sformatf("mul_stall_%0d", i), 4'b0000, 1'b1, 1'b1);
    end
    issue(0, 5'd0, 0, 3'd0);
    step("mul_release", 4'b0000, 1'b0, 1'b0);

    // WAW: lat 5 then lat 2 one cycle later keeps 4 remaining
    idle(); issue(1, 5'd4, 1, 3'd5);
    step("waw_first", 4'b0000, 1'b0, 1'b0);
    issue(1, 5'd4, 1, 3'd2);
    step("waw_second", 4'b0000, 1'b0, 1'b1);
    idle(); hfu_if.i_id_rs = {5'd0, 5'd4};
    for (int i = 0; i < 4; i++)
      step($sformatf("waw_busy_%0d", i), 4'b0000, 1'b1, 1'b1);
    step("waw_release", 4'b0000, 1'b0, 1'b0);

`ifdef HFU_PERF_CNT_EN
    idle(); i_rst_n = 1'b0;
    step("perf_reset", 4'b0000, 1'b0, 1'b0);
    i_rst_n = 1'b1;
    issue(1, 5'd11, 1, 3'd3);
    step("perf_issue_a", 4'b0000, 1'b0, 1'b0);
    idle(); hfu_if.i_id_rs = {5'd0, 5'd11};
    for (int i = 0; i < 3; i++)
      step($sformatf("perf_stall_a_%0d", i), 4'b0000, 1'b1, 1'b1);
    idle();
    step("perf_gap", 4'b0000, 1'b0, 1'b0);
    issue(1, 5'd12, 1, 3'd1);
    step("perf_issue_b", 4'b0000, 1'b0, 1'b0);
    idle(); hfu_if.i_id_rs = {5'd12, 5'd0};
    step("perf_stall_b", 4'b0000, 1'b1, 1'b1);
    idle();
    step("perf_idle", 4'b0000, 1'b0, 1'b0);
    total++;
    if (hfu_if.o_stall_cycles !== 32'd4) begin
      bad++;
      $display("FAIL perf_stall_cycles: got %0d want 4", hfu_if.o_stall_cycles);
    end
    total++;
    if (hfu_if.o_stall_events !== 32'd2) begin
      bad++;
      $display("FAIL perf_stall_events: got %0d want 2", hfu_if.o_stall_events);
    end
`endif

    @(posedge i_clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: %0d entries left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
